bitcoin_mem_host: RTL and testbench

Host-side companion to the bitcoin hash core. It owns the core's word memory and answers the core's memory port: registered read, one-cycle latency, synchronous write. It also sequences one job end to end:
- accept the 19-word block header over a valid/ready input stream;
- pulse the core's start and wait for completion, with a watchdog;
- stream the 16 per-nonce result words out over a valid/ready output stream.

---
 rtl/bitcoin_mem_host_if.sv | 31 +++
 rtl/bitcoin_mem_host.sv | 161 ++++++++++++++++
 tb/tb_bitcoin_mem_host.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitcoin_mem_host_if.sv
// Bundles the header input stream, result output stream and the hash core's
// control/memory port.
interface bitcoin_mem_host_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  in_valid, in_data, out_ready, core_done, mem_we, mem_addr, mem_write_data,
    output in_ready, out_valid, out_data, out_last, core_start, core_message_addr,
           core_output_addr, mem_read_data
  );

  modport master (
    output in_valid, in_data, out_ready, core_done, mem_we, mem_addr, mem_write_data,
    input  in_ready, out_valid, out_data, out_last, core_start, core_message_addr,
           core_output_addr, mem_read_data
  );
endinterface

// File: rtl/bitcoin_mem_host.sv
// Host companion to the bitcoin hash core: owns the core's word memory, loads a
// header, kicks the core under a watchdog and streams the result words out.
module bitcoin_mem_host #(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned MSG_BASE   = 0,
  parameter int unsigned OUT_BASE   = 32,
  parameter int unsigned MSG_WORDS  = 19,
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned TIMEOUT    = 8192
) (
  input  logic              clk,
  input  logic              reset,
  bitcoin_mem_host_if.slave bus,
  output logic              busy,
  output logic              timeout,
  output logic              wr_err
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {StLoad, StKick, StArm, StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  nonce_q, nonce_d;
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
  logic        wr_err_q, wr_err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]   mem [MEM_WORDS];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic in_hs, out_hs, core_active, core_in_range, wd_expired;

  always_comb begin
    in_hs         = (state_q == StLoad) && bus.in_valid;
    out_hs        = (state_q == StDrain) && bus.out_ready;
    core_active   = (state_q == StArm) || (state_q == StRun);
    core_in_range = 32'(bus.mem_addr) < MEM_WORDS;
    // Expires on the edge where the count reaches TIMEOUT, i.e. after TIMEOUT cycles.
    wd_expired    = (wd_q == 16'(TIMEOUT - 1));

    state_d   = state_q;
    idx_d     = idx_q;
    nonce_d   = nonce_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    wr_err_d  = wr_err_q;
    rdata_d   = rdata_q;
    wr_en     = 1'b0;
    wr_addr   = AW'(MSG_BASE + 32'(idx_q));
    wr_data   = bus.in_data;

    if (core_active && (wd_q != 16'hFFFF)) wd_d = wd_q + 16'd1;

    case (state_q)
      StLoad: begin
        if (in_hs) begin
          wr_en = 1'b1;
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'd0) begin
            timeout_d = 1'b0;
            wr_err_d  = 1'b0;
          end
          if (idx_q == 8'(MSG_WORDS - 1)) begin
            idx_d   = 8'd0;
            state_d = StKick;
          end
        end
      end
      StKick: begin
        wd_d    = 16'd0;
        state_d = StArm;
      end
      StArm: begin
        if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = StLoad;
        end else if (!bus.core_done) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = StLoad;
        end else if (bus.core_done) begin
          nonce_d = 8'd0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_hs) begin
          nonce_d = nonce_q + 8'd1;
          if (nonce_q == 8'(NUM_NONCES - 1)) begin
            nonce_d = 8'd0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    // Core port; read uses the pre-edge array so same-address writes return old data.
    if (core_active) begin
      rdata_d = core_in_range ? mem[bus.mem_addr[AW-1:0]] : 32'd0;
      if (bus.mem_we) begin
        if (core_in_range) begin
          wr_en   = 1'b1;
          wr_addr = bus.mem_addr[AW-1:0];
          wr_data = bus.mem_write_data;
        end else begin
          wr_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLoad;
      idx_q     <= 8'd0;
      nonce_q   <= 8'd0;
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nonce_q   <= nonce_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      wr_err_q  <= wr_err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    bus.in_ready          = (state_q == StLoad);
    bus.out_valid         = (state_q == StDrain);
    bus.out_data          = (state_q == StDrain) ? mem[AW'(OUT_BASE + 32'(nonce_q))] : 32'd0;
    bus.out_last          = (state_q == StDrain) && (nonce_q == 8'(NUM_NONCES - 1));
    bus.core_start        = (state_q == StKick);
    bus.core_message_addr = 16'(MSG_BASE);
    bus.core_output_addr  = 16'(OUT_BASE);
    bus.mem_read_data     = rdata_q;
    busy                  = (state_q != StLoad);
    timeout               = timeout_q;
    wr_err                = wr_err_q;
  end

endmodule

// File: tb/tb_bitcoin_mem_host.sv
// Directed self-checking bench for bitcoin_mem_host with a behavioural hash core.
module tb_bitcoin_mem_host;
  logic clk = 1'b0;
  logic reset;
  logic busy, timeout, wr_err;
  int   n_checks = 0;
  int   n_pass = 0;

  bitcoin_mem_host_if bus ();

  bitcoin_mem_host dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .timeout (timeout),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic load_header(input logic [31:0] base, output int hs);
    hs = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 19; k++) begin
      bus.in_data = base + 32'(k);
      if (bus.in_ready) hs++;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // From KICK: leave idle, then write 16 result words while in RUN.
  task automatic core_run(input logic [31:0] pat);
    tick();
    bus.core_done = 1'b0;
    tick();
    for (int n = 0; n < 16; n++) begin
      bus.mem_we         = 1'b1;
      bus.mem_addr       = 16'(32 + n);
      bus.mem_write_data = pat + 32'(n);
      tick();
    end
    bus.mem_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_core_start", 32'(bus.core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_rdata", bus.mem_read_data, 32'd0);
    chk("msg_addr", 32'(bus.core_message_addr), 32'd0);
    chk("out_addr", 32'(bus.core_output_addr), 32'd32);
  endtask

  task automatic test_main();
    int hs;
    load_header(32'h0, hs);
    chk("main_handshakes", 32'(hs), 32'd19);
    chk("main_in_ready_drop", 32'(bus.in_ready), 32'd0);
    chk("main_start_pulse", 32'(bus.core_start), 32'd1);
    chk("main_busy", 32'(busy), 32'd1);
    tick();
    chk("main_start_single", 32'(bus.core_start), 32'd0);
    bus.core_done = 1'b0;
    tick();
    for (int n = 0; n < 16; n++) begin
      bus.mem_we         = 1'b1;
      bus.mem_addr       = 16'(32 + n);
      bus.mem_write_data = 32'hA000_0000 + 32'(n);
      tick();
    end
    bus.mem_we   = 1'b0;
    bus.mem_addr = 16'd5;
    tick();
    chk("read_addr5", bus.mem_read_data, 32'h5);
    bus.mem_addr = 16'd70;
    tick();
    chk("read_addr70", bus.mem_read_data, 32'h0);
    bus.mem_addr = 16'd6;
    chk("read_latency_hold", bus.mem_read_data, 32'h0);
    tick();
    chk("read_addr6", bus.mem_read_data, 32'h6);
    chk("wr_err_clear", 32'(wr_err), 32'd0);
    bus.mem_we         = 1'b1;
    bus.mem_addr       = 16'd100;
    bus.mem_write_data = 32'hDEAD_BEEF;
    tick();
    bus.mem_we = 1'b0;
    chk("wr_err_set", 32'(wr_err), 32'd1);
    bus.mem_addr = 16'd36;
    tick();
    chk("oob_write_dropped", bus.mem_read_data, 32'hA000_0004);
    chk("no_early_valid", 32'(bus.out_valid), 32'd0);
    bus.core_done = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    for (int w = 0; w < 16; w++) begin
      chk($sformatf("main_valid%0d", w), 32'(bus.out_valid), 32'd1);
      chk($sformatf("main_data%0d", w), bus.out_data, 32'hA000_0000 + 32'(w));
      chk($sformatf("main_last%0d", w), 32'(bus.out_last), (w == 15) ? 32'd1 : 32'd0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("main_done_valid", 32'(bus.out_valid), 32'd0);
    chk("main_done_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic test_stall();
    int hs;
    int got;
    logic rdy, stalled;
    logic [31:0] held;
    load_header(32'h0, hs);
    chk("stall_handshakes", 32'(hs), 32'd19);
    chk("stall_wr_err_cleared", 32'(wr_err), 32'd0);
    core_run(32'hC0DE_0000);
    bus.core_done = 1'b1;
    tick();
    got     = 0;
    rdy     = 1'b1;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 64 && got < 16; c++) begin
      bus.out_ready = rdy;
      if (stalled) begin
        chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        chk("stall_data_held", bus.out_data, held);
      end
      if (bus.out_valid && rdy) begin
        chk($sformatf("stall_data%0d", got), bus.out_data, 32'hC0DE_0000 + 32'(got));
        chk($sformatf("stall_last%0d", got), 32'(bus.out_last), (got == 15) ? 32'd1 : 32'd0);
        got++;
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held    = bus.out_data;
      end
      tick();
      rdy = ~rdy;
    end
    bus.out_ready = 1'b0;
    chk("stall_word_count", 32'(got), 32'd16);
    chk("stall_end_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic test_timeout();
    int hs;
    int cyc;
    int bad;
    load_header(32'h55, hs);
    chk("to_handshakes", 32'(hs), 32'd19);
    tick();
    cyc = 0;
    bad = 0;
    while (!timeout && cyc < 9000) begin
      if (bus.out_valid || bus.in_ready || !busy) bad++;
      tick();
      cyc++;
    end
    chk("to_stuck_in_arm", 32'(bad), 32'd0);
    chk("to_cycles", 32'(cyc), 32'd8192);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_in_ready", 32'(bus.in_ready), 32'd1);
    chk("to_no_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("to_sticky", 32'(timeout), 32'd1);
  endtask

  task automatic test_reset_mid();
    int hs;
    load_header(32'h0, hs);
    chk("mid_timeout_cleared", 32'(timeout), 32'd0);
    tick();
    bus.core_done = 1'b0;
    tick();
    bus.core_done = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    for (int w = 0; w < 7; w++) tick();
    bus.out_ready = 1'b0;
    chk("mid_word7", bus.out_data, 32'hC0DE_0007);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    load_header(32'h100, hs);
    chk("mid_reload_handshakes", 32'(hs), 32'd19);
    chk("mid_reload_start", 32'(bus.core_start), 32'd1);
    tick();
    bus.core_done = 1'b0;
    tick();
    bus.mem_addr = 16'd3;
    tick();
    chk("mid_reload_data", bus.mem_read_data, 32'h103);
    bus.mem_addr = 16'd18;
    tick();
    chk("mid_reload_last_word", bus.mem_read_data, 32'h112);
    bus.core_done = 1'b1;
    reset         = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.out_ready      = 1'b0;
    bus.core_done      = 1'b1;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    test_reset();
    test_main();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
